// File: rtl/control_unit.sv
// Multicycle control FSM for the CPU datapath: fetch/decode/execute/memory/writeback
// plus the overflow and bad-opcode exception path.
module control_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ula_zero,
  input  logic       ula_overflow,
  output logic       pc_write,
  output logic [1:0] crtl_iord,
  output logic [1:0] crtl_error,
  output logic       crtl_memwrite,
  output logic [1:0] crtl_ss,
  output logic       crtl_irwrite,
  output logic       crtl_memDataRegWrite,
  output logic       crtl_rega,
  output logic       crtl_regb,
  output logic       crtl_regaluout,
  output logic       crtl_regepc,
  output logic       crtl_regwrite,
  output logic [2:0] crtl_regdst,
  output logic [3:0] crtl_memtoreg,
  output logic       crtl_ulasrca,
  output logic [1:0] crtl_ulasrcb,
  output logic [2:0] crtl_ula_op,
  output logic [2:0] crtl_pcsource,
  output logic       crtl_ls
);

  localparam logic [4:0] S_RESET    = 5'd0,  S_FETCH  = 5'd1,  S_FETCH_W = 5'd2,
                         S_DECODE   = 5'd3,  S_EXEC_R = 5'd4,  S_WB_R    = 5'd5,
                         S_SLT      = 5'd6,  S_JR     = 5'd7,  S_ADDI    = 5'd8,
                         S_WB_I     = 5'd9,  S_MEM_ADDR = 5'd10, S_LW_W  = 5'd11,
                         S_LW_WB    = 5'd12, S_SW     = 5'd13, S_BRANCH  = 5'd14,
                         S_JUMP     = 5'd15, S_JAL    = 5'd16, S_EXC_EPC = 5'd17,
                         S_EXC_W    = 5'd18, S_EXC_PC = 5'd19;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24,
                         F_SLT = 6'h2A;

  localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  logic [4:0]    state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    err_code, next_code;
  logic          wait_done, next_is_wait, r_arith;

  assign wait_done    = (wait_cnt == '0);
  assign next_is_wait = (next_state == S_FETCH_W) || (next_state == S_LW_W) ||
                        (next_state == S_EXC_W);
  assign r_arith      = (funct == F_ADD) || (funct == F_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      wait_cnt <= '0;
      err_code <= 2'd0;
    end else begin
      state <= next_state;
      if (next_is_wait && (next_state != state))
        wait_cnt <= CW'(MEM_RD_LAT - 1);
      else if (!wait_done)
        wait_cnt <= wait_cnt - CW'(1);
      if (next_state == S_EXC_EPC)
        err_code <= next_code;
    end
  end

  always_comb begin
    next_state = state;
    next_code  = 2'd0;
    case (state)
      S_RESET:   next_state = S_FETCH;
      S_FETCH:   next_state = S_FETCH_W;
      S_FETCH_W: if (wait_done) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R: begin
            case (funct)
              F_ADD, F_SUB, F_AND: next_state = S_EXEC_R;
              F_SLT:               next_state = S_SLT;
              F_JR:                next_state = S_JR;
              default:             next_state = S_EXC_EPC;
            endcase
          end
          OP_ADDI:      next_state = S_ADDI;
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_EXC_EPC;
        endcase
      end
      S_EXEC_R: begin
        if (r_arith && ula_overflow) begin
          next_state = S_EXC_EPC;
          next_code  = 2'd1;
        end else begin
          next_state = S_WB_R;
        end
      end
      S_ADDI: begin
        if (ula_overflow) begin
          next_state = S_EXC_EPC;
          next_code  = 2'd1;
        end else begin
          next_state = S_WB_I;
        end
      end
      S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_LW_W : S_SW;
      S_LW_W:     if (wait_done) next_state = S_LW_WB;
      S_EXC_EPC:  next_state = S_EXC_W;
      S_EXC_W:    if (wait_done) next_state = S_EXC_PC;
      S_WB_R, S_SLT, S_JR, S_WB_I, S_LW_WB, S_SW, S_BRANCH, S_JUMP, S_JAL, S_EXC_PC:
                  next_state = S_FETCH;
      default:    next_state = S_RESET;
    endcase
  end

  // Wait states hold the address/ALU setup throughout; IR, MDR and PC loads fire
  // only on the final cycle, when the read data is valid and PC advances exactly once.
  always_comb begin
    pc_write             = 1'b0;
    crtl_iord            = 2'd0;
    crtl_error           = 2'd0;
    crtl_memwrite        = 1'b0;
    crtl_ss              = 2'd0;
    crtl_irwrite         = 1'b0;
    crtl_memDataRegWrite = 1'b0;
    crtl_rega            = 1'b0;
    crtl_regb            = 1'b0;
    crtl_regaluout       = 1'b0;
    crtl_regepc          = 1'b0;
    crtl_regwrite        = 1'b0;
    crtl_regdst          = 3'd0;
    crtl_memtoreg        = 4'd0;
    crtl_ulasrca         = 1'b0;
    crtl_ulasrcb         = 2'd0;
    crtl_ula_op          = 3'b000;
    crtl_pcsource        = 3'd0;
    crtl_ls              = 1'b0;
    case (state)
      S_FETCH_W: begin
        crtl_ulasrcb = 2'd1;
        crtl_ula_op  = 3'b001;
        crtl_irwrite = wait_done;
        pc_write     = wait_done;
      end
      S_DECODE: begin
        crtl_rega      = 1'b1;
        crtl_regb      = 1'b1;
        crtl_regaluout = 1'b1;
        crtl_ulasrcb   = 2'd3;
        crtl_ula_op    = 3'b001;
      end
      S_EXEC_R: begin
        crtl_ulasrca   = 1'b1;
        crtl_regaluout = 1'b1;
        crtl_ula_op    = (funct == F_SUB) ? 3'b010 : (funct == F_AND) ? 3'b011 : 3'b001;
      end
      S_WB_R: begin
        crtl_regwrite = 1'b1;
        crtl_regdst   = 3'd2;
        crtl_memtoreg = 4'd1;
      end
      S_SLT: begin
        crtl_ulasrca  = 1'b1;
        crtl_ula_op   = 3'b111;
        crtl_regwrite = 1'b1;
        crtl_regdst   = 3'd2;
        crtl_memtoreg = 4'd5;
      end
      S_ADDI, S_MEM_ADDR: begin
        crtl_ulasrca   = 1'b1;
        crtl_ulasrcb   = 2'd2;
        crtl_ula_op    = 3'b001;
        crtl_regaluout = 1'b1;
      end
      S_WB_I: begin
        crtl_regwrite = 1'b1;
        crtl_memtoreg = 4'd1;
      end
      S_LW_W: begin
        crtl_iord            = 2'd2;
        crtl_memDataRegWrite = wait_done;
      end
      S_LW_WB: begin
        crtl_regwrite = 1'b1;
        crtl_memtoreg = 4'd4;
      end
      S_SW: begin
        crtl_iord     = 2'd2;
        crtl_memwrite = 1'b1;
      end
      S_BRANCH: begin
        crtl_ulasrca  = 1'b1;
        crtl_ula_op   = 3'b010;
        crtl_pcsource = 3'd2;
        pc_write      = (opcode == OP_BEQ) ? ula_zero : !ula_zero;
      end
      S_JUMP: begin
        crtl_pcsource = 3'd4;
        pc_write      = 1'b1;
      end
      S_JAL: begin
        crtl_pcsource = 3'd4;
        pc_write      = 1'b1;
        crtl_regwrite = 1'b1;
        crtl_regdst   = 3'd3;
        crtl_memtoreg = 4'd8;
      end
      S_JR: begin
        crtl_pcsource = 3'd3;
        pc_write      = 1'b1;
      end
      S_EXC_EPC: begin
        crtl_regepc  = 1'b1;
        crtl_ulasrcb = 2'd1;
        crtl_ula_op  = 3'b010;
      end
      S_EXC_W: begin
        crtl_iord            = 2'd1;
        crtl_error           = err_code;
        crtl_memDataRegWrite = wait_done;
      end
      S_EXC_PC: begin
        crtl_ls       = 1'b1;
        crtl_pcsource = 3'd5;
        pc_write      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: two instances (read latency 1 and 3) checked cycle by cycle
// against per-state expected control words queued when each instruction is driven.
module tb_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] iord;
    logic [1:0] err;
    logic       memwrite;
    logic [1:0] ss;
    logic       irwrite;
    logic       mdr;
    logic       rega;
    logic       regb;
    logic       aluout;
    logic       epc;
    logic       regwrite;
    logic [2:0] regdst;
    logic [3:0] memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] op;
    logic [2:0] pcsrc;
    logic       ls;
  } cw_t;

  typedef enum logic [4:0] {
    T_RESET, T_FETCH, T_FW, T_DEC, T_EXR, T_WBR, T_SLT, T_JR, T_ADDI, T_WBI, T_MA,
    T_LWW, T_LWWB, T_SW, T_BR, T_J, T_JAL, T_EPC, T_EXW, T_EXPC, T_END
  } tok_t;

  typedef struct {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       ovf;
    logic [1:0] code;
    tok_t       tail [4];
  } vec_t;

  logic       clk, rst;
  logic [5:0] opcode, funct;
  logic       ula_zero, ula_overflow;

  logic [1:0]      pc_write, memwrite, irwrite, mdr, rega, regb, aluout, epc, regwrite, srca, ls;
  logic [1:0][1:0] iord, err, ss, srcb;
  logic [1:0][2:0] regdst, op, pcsrc;
  logic [1:0][3:0] memtoreg;

  int   n_checks = 0;
  int   n_fail   = 0;
  cw_t  q0 [$];
  cw_t  q1 [$];
  vec_t vecs [17];

  control_unit #(.MEM_RD_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ula_zero(ula_zero),
    .ula_overflow(ula_overflow), .pc_write(pc_write[0]), .crtl_iord(iord[0]),
    .crtl_error(err[0]), .crtl_memwrite(memwrite[0]), .crtl_ss(ss[0]),
    .crtl_irwrite(irwrite[0]), .crtl_memDataRegWrite(mdr[0]), .crtl_rega(rega[0]),
    .crtl_regb(regb[0]), .crtl_regaluout(aluout[0]), .crtl_regepc(epc[0]),
    .crtl_regwrite(regwrite[0]), .crtl_regdst(regdst[0]), .crtl_memtoreg(memtoreg[0]),
    .crtl_ulasrca(srca[0]), .crtl_ulasrcb(srcb[0]), .crtl_ula_op(op[0]),
    .crtl_pcsource(pcsrc[0]), .crtl_ls(ls[0])
  );

  control_unit #(.MEM_RD_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ula_zero(ula_zero),
    .ula_overflow(ula_overflow), .pc_write(pc_write[1]), .crtl_iord(iord[1]),
    .crtl_error(err[1]), .crtl_memwrite(memwrite[1]), .crtl_ss(ss[1]),
    .crtl_irwrite(irwrite[1]), .crtl_memDataRegWrite(mdr[1]), .crtl_rega(rega[1]),
    .crtl_regb(regb[1]), .crtl_regaluout(aluout[1]), .crtl_regepc(epc[1]),
    .crtl_regwrite(regwrite[1]), .crtl_regdst(regdst[1]), .crtl_memtoreg(memtoreg[1]),
    .crtl_ulasrca(srca[1]), .crtl_ulasrcb(srcb[1]), .crtl_ula_op(op[1]),
    .crtl_pcsource(pcsrc[1]), .crtl_ls(ls[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cw_t act_word(int d);
    return {pc_write[d], iord[d], err[d], memwrite[d], ss[d], irwrite[d], mdr[d], rega[d],
            regb[d], aluout[d], epc[d], regwrite[d], regdst[d], memtoreg[d], srca[d],
            srcb[d], op[d], pcsrc[d], ls[d]};
  endfunction

  // Expected control word for one cycle of a state; 'last' marks the final wait cycle.
  function automatic cw_t exp_word(tok_t t, logic last, vec_t v);
    cw_t w;
    w = '0;
    case (t)
      T_FW:   begin w.srcb = 2'd1; w.op = 3'b001; w.irwrite = last; w.pc_write = last; end
      T_DEC:  begin w.rega = 1; w.regb = 1; w.aluout = 1; w.srcb = 2'd3; w.op = 3'b001; end
      T_EXR:  begin
        w.srca = 1; w.aluout = 1;
        w.op = (v.funct == 6'h22) ? 3'b010 : (v.funct == 6'h24) ? 3'b011 : 3'b001;
      end
      T_WBR:  begin w.regwrite = 1; w.regdst = 3'd2; w.memtoreg = 4'd1; end
      T_SLT:  begin w.srca = 1; w.op = 3'b111; w.regwrite = 1; w.regdst = 3'd2; w.memtoreg = 4'd5; end
      T_JR:   begin w.pcsrc = 3'd3; w.pc_write = 1; end
      T_ADDI, T_MA: begin w.srca = 1; w.srcb = 2'd2; w.op = 3'b001; w.aluout = 1; end
      T_WBI:  begin w.regwrite = 1; w.memtoreg = 4'd1; end
      T_LWW:  begin w.iord = 2'd2; w.mdr = last; end
      T_LWWB: begin w.regwrite = 1; w.memtoreg = 4'd4; end
      T_SW:   begin w.iord = 2'd2; w.memwrite = 1; end
      T_BR:   begin
        w.srca = 1; w.op = 3'b010; w.pcsrc = 3'd2;
        w.pc_write = (v.opcode == 6'h04) ? v.zero : ~v.zero;
      end
      T_J:    begin w.pcsrc = 3'd4; w.pc_write = 1; end
      T_JAL:  begin w.pcsrc = 3'd4; w.pc_write = 1; w.regwrite = 1; w.regdst = 3'd3; w.memtoreg = 4'd8; end
      T_EPC:  begin w.epc = 1; w.srcb = 2'd1; w.op = 3'b010; end
      T_EXW:  begin w.iord = 2'd1; w.err = v.code; w.mdr = last; end
      T_EXPC: begin w.ls = 1; w.pcsrc = 3'd5; w.pc_write = 1; end
      default: ;
    endcase
    return w;
  endfunction

  function automatic vec_t mk(logic [5:0] o, logic [5:0] f, logic z, logic ov, logic [1:0] c,
                              tok_t t0, tok_t t1, tok_t t2, tok_t t3);
    vec_t v;
    v.opcode = o; v.funct = f; v.zero = z; v.ovf = ov; v.code = c;
    v.tail[0] = t0; v.tail[1] = t1; v.tail[2] = t2; v.tail[3] = t3;
    return v;
  endfunction

  task automatic push_tok(tok_t t, vec_t v);
    for (int d = 0; d < 2; d++) begin
      int lat;
      int reps;
      lat  = (d == 0) ? 1 : 3;
      reps = (t == T_FW || t == T_LWW || t == T_EXW) ? lat : 1;
      for (int k = 0; k < reps; k++) begin
        if (d == 0) q0.push_back(exp_word(t, k == reps - 1, v));
        else        q1.push_back(exp_word(t, k == reps - 1, v));
      end
    end
  endtask

  task automatic check_word(int d, cw_t exp, string name);
    cw_t act;
    act = act_word(d);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lat%0d: got %h expected %h", name, (d == 0) ? 1 : 3, act, exp);
    end
  endtask

  task automatic run_vec(int idx, vec_t v);
    int n;
    opcode = v.opcode; funct = v.funct; ula_zero = v.zero; ula_overflow = v.ovf;
    rst = 1'b1;
    q0.delete(); q1.delete();
    push_tok(T_RESET, v); push_tok(T_FETCH, v); push_tok(T_FW, v); push_tok(T_DEC, v);
    for (int i = 0; i < 4; i++)
      if (v.tail[i] != T_END) push_tok(v.tail[i], v);
    push_tok(T_FETCH, v);
    @(posedge clk); #1 rst = 1'b0;
    n = q1.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (q0.size() != 0) check_word(0, q0.pop_front(), $sformatf("vec%0d cyc%0d", idx, c));
      if (q1.size() != 0) check_word(1, q1.pop_front(), $sformatf("vec%0d cyc%0d", idx, c));
    end
  endtask

  initial begin
    vec_t lw;
    rst = 1'b1; opcode = '0; funct = '0; ula_zero = 1'b0; ula_overflow = 1'b0;

    vecs[0]  = mk(6'h00, 6'h20, 0, 0, 0, T_EXR,  T_WBR, T_END,  T_END);   // add
    vecs[1]  = mk(6'h00, 6'h22, 0, 1, 1, T_EXR,  T_EPC, T_EXW,  T_EXPC);  // sub overflow
    vecs[2]  = mk(6'h00, 6'h24, 0, 1, 0, T_EXR,  T_WBR, T_END,  T_END);   // and ignores ovf
    vecs[3]  = mk(6'h00, 6'h2A, 0, 1, 0, T_SLT,  T_END, T_END,  T_END);   // slt ignores ovf
    vecs[4]  = mk(6'h00, 6'h08, 0, 0, 0, T_JR,   T_END, T_END,  T_END);   // jr
    vecs[5]  = mk(6'h00, 6'h3F, 0, 0, 0, T_EPC,  T_EXW, T_EXPC, T_END);   // bad funct
    vecs[6]  = mk(6'h08, 6'h00, 0, 0, 0, T_ADDI, T_WBI, T_END,  T_END);   // addi
    vecs[7]  = mk(6'h08, 6'h00, 0, 1, 1, T_ADDI, T_EPC, T_EXW,  T_EXPC);  // addi overflow
    vecs[8]  = mk(6'h23, 6'h08, 0, 1, 0, T_MA,   T_LWW, T_LWWB, T_END);   // lw
    vecs[9]  = mk(6'h2B, 6'h08, 0, 0, 0, T_MA,   T_SW,  T_END,  T_END);   // sw
    vecs[10] = mk(6'h04, 6'h02, 1, 0, 0, T_BR,   T_END, T_END,  T_END);   // beq taken
    vecs[11] = mk(6'h04, 6'h02, 0, 0, 0, T_BR,   T_END, T_END,  T_END);   // beq not taken
    vecs[12] = mk(6'h05, 6'h02, 1, 0, 0, T_BR,   T_END, T_END,  T_END);   // bne same regs
    vecs[13] = mk(6'h05, 6'h02, 0, 1, 0, T_BR,   T_END, T_END,  T_END);   // bne taken
    vecs[14] = mk(6'h02, 6'h10, 0, 0, 0, T_J,    T_END, T_END,  T_END);   // j
    vecs[15] = mk(6'h03, 6'h10, 0, 1, 0, T_JAL,  T_END, T_END,  T_END);   // jal
    vecs[16] = mk(6'h3F, 6'h20, 0, 1, 0, T_EPC,  T_EXW, T_EXPC, T_END);   // bad opcode

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a lw read: latency-3 unit is in its first LW_W cycle.
    lw = vecs[8];
    opcode = lw.opcode; funct = lw.funct; ula_zero = 1'b0; ula_overflow = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 8; c++) @(negedge clk);
    check_word(1, exp_word(T_LWW, 1'b0, lw), "lw_wait_hold");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_word(0, '0, "rst_mid_reset");
    check_word(1, '0, "rst_mid_reset");
    @(negedge clk);
    check_word(1, '0, "rst_mid_fetch");
    @(negedge clk);
    check_word(0, exp_word(T_FW, 1'b1, lw), "rst_mid_fetch_w");
    check_word(1, exp_word(T_FW, 1'b0, lw), "rst_mid_fetch_w");
    @(negedge clk);
    check_word(1, exp_word(T_FW, 1'b0, lw), "rst_mid_fetch_w2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
